// File: rtl/hop_seq_pkg.sv
// Shared types and constants for the per-hop reset sequencer.
package hop_seq_pkg;

    // Sequencer states: all hops held, releasing upward, all released, asserting downward.
    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        ASSERT  = 2'd3
    } hop_seq_state_t;

    localparam int DEF_NUM_HOPS = 6;
    localparam int DEF_GAP_W    = 4;

    // Widest reset vector the mask helper can describe.
    localparam int MAX_HOPS = 32;

    // Mask with the low n bits set; used to build the "every hop in reset" value.
    function automatic logic [MAX_HOPS-1:0] hop_mask(input int unsigned n);
        logic [MAX_HOPS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_HOPS; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/hop_gap_counter.sv
// Load / decrement down-counter that times the gap between successive hops.
// It saturates at zero so a long idle stretch never wraps into a new gap.
module hop_gap_counter #(
    parameter int GAP_W = 4
) (
    input  logic             clock0,
    input  logic             rst0,
    input  logic             load,
    input  logic [GAP_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [GAP_W-1:0] cnt;

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge clock0) begin
        if (rst0) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - GAP_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hop_reset_sequencer.sv
// Per-hop reset controller: releases hop resets from hop 0 upward and
// re-asserts them from the last hop downward, spacing hops by gap_q+1 cycles.
// All outputs come straight from flops.
module hop_reset_sequencer
    import hop_seq_pkg::*;
#(
    parameter int NUM_HOPS = DEF_NUM_HOPS,
    parameter int GAP_W    = DEF_GAP_W,
    parameter int IDX_W    = $clog2(NUM_HOPS)
) (
    input  logic                clock0,
    input  logic                rst0,
    input  logic                start,
    input  logic                assert_req,
    input  logic [GAP_W-1:0]    gap,
    output logic [NUM_HOPS-1:0] rst_out,
    output logic                busy,
    output logic                done,
    output logic [IDX_W-1:0]    hop_idx
);

    localparam logic [MAX_HOPS-1:0] MASK_FULL = hop_mask(NUM_HOPS);
    localparam logic [NUM_HOPS-1:0] RST_ALL   = MASK_FULL[NUM_HOPS-1:0];
    localparam logic [IDX_W-1:0]    LAST_HOP  = IDX_W'(NUM_HOPS - 1);

    hop_seq_state_t      state, state_n;
    logic [NUM_HOPS-1:0] rst_out_n;
    logic [IDX_W-1:0]    hop_idx_n;
    logic [GAP_W-1:0]    gap_q, gap_q_n;
    logic                busy_n, done_n;
    logic                cnt_load, cnt_dec, cnt_zero;
    logic [GAP_W-1:0]    cnt_load_val;

    hop_gap_counter #(
        .GAP_W (GAP_W)
    ) u_gap_counter (
        .clock0   (clock0),
        .rst0     (rst0),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State, reset vector, hop pointer, latched gap and status flags.
    always_ff @(posedge clock0) begin
        if (rst0) begin
            state   <= HOLD;
            rst_out <= RST_ALL;
            hop_idx <= '0;
            gap_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            rst_out <= rst_out_n;
            hop_idx <= hop_idx_n;
            gap_q   <= gap_q_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    // Next-state and next-output decode; a hop is touched only when the gap count is zero.
    always_comb begin
        state_n      = state;
        rst_out_n    = rst_out;
        hop_idx_n    = hop_idx;
        gap_q_n      = gap_q;
        cnt_load     = 1'b0;
        cnt_load_val = gap_q;
        cnt_dec      = 1'b0;

        unique case (state)
            HOLD: begin
                rst_out_n = RST_ALL;
                // start beats a simultaneous assert_req; assert_req alone does nothing here.
                if (start) begin
                    gap_q_n      = gap;
                    cnt_load     = 1'b1;
                    cnt_load_val = gap;
                    hop_idx_n    = '0;
                    state_n      = RELEASE;
                end
            end
            RELEASE: begin
                if (assert_req) begin
                    // Abort: slam every hop back into reset, keep hop_idx for inspection.
                    rst_out_n = RST_ALL;
                    state_n   = HOLD;
                end else if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    rst_out_n[hop_idx] = 1'b0;
                    if (hop_idx == LAST_HOP) begin
                        state_n = RUN;
                    end else begin
                        hop_idx_n = hop_idx + IDX_W'(1);
                        cnt_load  = 1'b1;
                    end
                end
            end
            RUN: begin
                rst_out_n = '0;
                if (assert_req) begin
                    gap_q_n      = gap;
                    cnt_load     = 1'b1;
                    cnt_load_val = gap;
                    hop_idx_n    = LAST_HOP;
                    state_n      = ASSERT;
                end
            end
            ASSERT: begin
                // Runs to completion regardless of start / assert_req.
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    rst_out_n[hop_idx] = 1'b1;
                    if (hop_idx == '0) begin
                        state_n = HOLD;
                    end else begin
                        hop_idx_n = hop_idx - IDX_W'(1);
                        cnt_load  = 1'b1;
                    end
                end
            end
            default: begin
                state_n   = HOLD;
                rst_out_n = RST_ALL;
            end
        endcase

        busy_n = (state_n == RELEASE) || (state_n == ASSERT);
        done_n = (state_n == RUN);
    end

endmodule

// File: tb/tb_hop_reset_sequencer.sv
// Directed bench for hop_reset_sequencer (NUM_HOPS=6, GAP_W=4).
// Inputs change 1ns after a rising edge; outputs are checked at that point,
// i.e. "after edge Ek" values.
module tb_hop_reset_sequencer;

    logic       clock0 = 1'b0;
    logic       rst0;
    logic       start;
    logic       assert_req;
    logic [3:0] gap;
    logic [5:0] rst_out;
    logic       busy;
    logic       done;
    logic [2:0] hop_idx;

    int checks = 0;
    int errors = 0;

    logic [5:0] exp_rst;

    hop_reset_sequencer dut (
        .clock0     (clock0),
        .rst0       (rst0),
        .start      (start),
        .assert_req (assert_req),
        .gap        (gap),
        .rst_out    (rst_out),
        .busy       (busy),
        .done       (done),
        .hop_idx    (hop_idx)
    );

    // Clock.
    always #5 clock0 = ~clock0;

    // Advance past one rising edge.
    task automatic tick();
        @(posedge clock0);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [5:0] e_rst, input logic e_busy,
                             input logic e_done);
        check({tag, ".rst_out"}, 32'(rst_out), 32'(e_rst));
        check({tag, ".busy"}, 32'(busy), 32'(e_busy));
        check({tag, ".done"}, 32'(done), 32'(e_done));
    endtask

    initial begin
        rst0 = 1'b1; start = 1'b0; assert_req = 1'b0; gap = 4'd0;

        // Reset state.
        tick(); tick();
        rst0 = 1'b0;
        check_all("reset", 6'h3F, 1'b0, 1'b0);
        check("reset.hop_idx", 32'(hop_idx), 0);

        // gap=0 release: one hop per cycle.
        gap = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check_all("rel0.e0", 6'h3F, 1'b1, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_rst = 6'h3F << k;
            check_all($sformatf("rel0.e%0d", k), exp_rst, (k <= 5), (k == 6));
        end
        check("rel0.hop_idx", 32'(hop_idx), 5);

        // start in RUN is ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        check_all("run_start", 6'h00, 1'b0, 1'b1);

        // Assert with gap=1; start/assert_req pulse mid-way is ignored.
        gap = 4'd1; assert_req = 1'b1;
        tick();
        assert_req = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 3) begin
                start = 1'b1; assert_req = 1'b1; gap = 4'd0;
            end else begin
                start = 1'b0; assert_req = 1'b0;
            end
            exp_rst = ~(6'h3F >> (k / 2));
            check($sformatf("asr1.e%0d", k), 32'(rst_out), 32'(exp_rst));
        end
        check_all("asr1.end", 6'h3F, 1'b0, 1'b0);
        check("asr1.hop_idx", 32'(hop_idx), 0);

        // assert_req alone in HOLD is ignored.
        assert_req = 1'b1;
        tick();
        assert_req = 1'b0;
        tick();
        check_all("hold_asr", 6'h3F, 1'b0, 1'b0);

        // gap=3 release; gap changed to 0 before E2 must not matter.
        gap = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 1) gap = 4'd0;
            exp_rst = 6'h3F << (k / 4);
            check($sformatf("rel3.e%0d", k), 32'(rst_out), 32'(exp_rst));
        end
        check_all("rel3.end", 6'h00, 1'b0, 1'b1);

        // rst0 from RUN, then rst0 mid-RELEASE.
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        check_all("rst_run", 6'h3F, 1'b0, 1'b0);
        gap = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        check("mid.rst_out", 32'(rst_out), 32'h3C);
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        check_all("rst_mid", 6'h3F, 1'b0, 1'b0);
        check("rst_mid.hop_idx", 32'(hop_idx), 0);

        // Abort: gap=2, assert_req at E5.
        gap = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        check("abort.e4", 32'(rst_out), 32'h3E);
        check("abort.e4.hop_idx", 32'(hop_idx), 1);
        assert_req = 1'b1;
        tick();
        assert_req = 1'b0;
        check_all("abort.e5", 6'h3F, 1'b0, 1'b0);
        check("abort.hop_idx", 32'(hop_idx), 1);
        tick();
        check_all("abort.hold", 6'h3F, 1'b0, 1'b0);

        // Clean restart after abort.
        gap = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("restart.e1", 32'(rst_out), 32'h3E);
        check("restart.e1.hop_idx", 32'(hop_idx), 1);
        repeat (5) tick();
        check_all("restart.e6", 6'h00, 1'b0, 1'b1);

        // Back to HOLD with gap=0 assert: 6 edges.
        assert_req = 1'b1;
        tick();
        assert_req = 1'b0;
        repeat (5) tick();
        check("asr0.e5", 32'(rst_out), 32'h3E);
        tick();
        check_all("asr0.e6", 6'h3F, 1'b0, 1'b0);

        // start and assert_req together in HOLD: release wins.
        start = 1'b1; assert_req = 1'b1;
        tick();
        start = 1'b0; assert_req = 1'b0;
        check_all("both.e0", 6'h3F, 1'b1, 1'b0);
        tick();
        check("both.e1", 32'(rst_out), 32'h3E);

        // Maximum gap: 16 cycles per hop, no counter wrap.
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        gap = 4'hF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        check("gmax.e15", 32'(rst_out), 32'h3F);
        tick();
        check("gmax.e16", 32'(rst_out), 32'h3E);
        repeat (15) tick();
        check("gmax.e31", 32'(rst_out), 32'h3E);
        tick();
        check("gmax.e32", 32'(rst_out), 32'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
